// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared encodings for the data-memory access unit.
// - Addressing-mode encodings carried on the 2-bit mode input.
// - FSM state encodings for the access sequencer.
// - Helper that says whether a mode writes an updated base register back.
// Optional feature macro used by the importing files: MEM_ACCESS_BOUNDS_CHECK_EN.
package mem_access_unit_pkg;

  // Addressing modes.
  localparam logic [1:0] mau_direct   = 2'b00;
  localparam logic [1:0] mau_indirect = 2'b01;
  localparam logic [1:0] mau_post_inc = 2'b10;
  localparam logic [1:0] mau_post_dec = 2'b11;

  // Access sequencer states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Both post-modify modes have the high mode bit set.
  function automatic logic mode_has_wb(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/mem_access_unit_addr_gen.sv
// mem_access_unit_addr_gen
// Combinational address and base-writeback generation.
// Ports:
//   mode      in   addressing mode (direct / indirect / post-inc / post-dec)
//   imm       in   immediate (direct) address
//   base      in   base register value (indirect address)
//   addr      out  zero-extended effective address
//   wb_value  out  base+1 for post-inc, base-1 for post-dec (wraps mod 2^DATA_W)
//   oob       out  effective address >= MEM_LIMIT (only with MEM_ACCESS_BOUNDS_CHECK_EN)
// Optional feature macro: MEM_ACCESS_BOUNDS_CHECK_EN adds the MEM_LIMIT
// parameter and the oob output.
module mem_access_unit_addr_gen
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  parameter int MEM_LIMIT = 1024,
`endif
  parameter int IMM_W     = 8
) (
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] base,
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  output logic              oob,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wb_value
);

  always_comb begin
    addr     = (mode == mau_direct) ? ADDR_W'(imm) : ADDR_W'(base);
    // Only meaningful for the post-modify modes; the top ignores it otherwise.
    wb_value = (mode == mau_post_dec) ? (base - DATA_W'(1)) : (base + DATA_W'(1));
  end

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  // Compared at 64 bits so a limit of exactly 2^ADDR_W is representable.
  assign oob = (64'(addr) >= 64'(MEM_LIMIT));
`endif

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory access path: DAR/MDR, direct and indirect addressing with
// optional post-increment/decrement writeback, load/store through a
// synchronous memory of fixed read latency, start/busy/done handshake.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start                 request, sampled only in IDLE
//   op_store              1 = store, 0 = load
//   mode                  00 direct, 01 indirect, 10 post-inc, 11 post-dec
//   imm, base, st_data    direct address, base register, store data
//   busy, done, err       status; done/err are one-cycle pulses
//   ld_data               last loaded word, held until the next load completes
//   base_wb, base_wb_en   updated base value and its write strobe
//   mem_addr, mem_w_en,
//   mem_d_out, mem_d_in   memory interface (DAR, write strobe, MDR, read data)
// Optional feature macro: MEM_ACCESS_BOUNDS_CHECK_EN. When defined, an access
// whose address is >= MEM_LIMIT skips ACCESS and completes with err=1.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int IMM_W     = 8,
  parameter int MEM_LAT   = 1,
  parameter int MEM_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_store,
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] st_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] base_wb,
  output logic              base_wb_en,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_d_out,
  input  logic [DATA_W-1:0] mem_d_in
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4 || ADDR_W < DATA_W || ADDR_W < IMM_W || MEM_LIMIT < 1)
    begin : g_param_check
      $error("mem_access_unit: illegal parameter combination");
    end
  endgenerate

  // Counter value during the last cycle of a load's ACCESS phase.
  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] dar_reg;
  logic [DATA_W-1:0] mdr_reg;
  logic [DATA_W-1:0] ld_data_reg;
  logic [DATA_W-1:0] base_wb_reg;
  logic [1:0]        lat_cnt_reg;
  logic              store_reg;
  logic              wb_en_reg;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wb_value;
  logic              skip_access;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  logic addr_oob;
  logic oob_reg;

  mem_access_unit_addr_gen #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_LIMIT (MEM_LIMIT),
    .IMM_W     (IMM_W)
  ) u_addr_gen (
    .mode     (mode),
    .imm      (imm),
    .base     (base),
    .oob      (addr_oob),
    .addr     (addr_sel),
    .wb_value (wb_value)
  );

  assign skip_access = addr_oob;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oob_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && start) begin
      oob_reg <= addr_oob;
    end
  end

  assign err = done & oob_reg;
`else
  mem_access_unit_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_addr_gen (
    .mode     (mode),
    .imm      (imm),
    .base     (base),
    .addr     (addr_sel),
    .wb_value (wb_value)
  );

  assign skip_access = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state logic. A store needs one ACCESS cycle; a load stays until the
  // counter reaches the last latency cycle. A start seen outside IDLE is dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = skip_access ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (store_reg || lat_cnt_reg == LAST_CNT) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      dar_reg     <= '0;
      mdr_reg     <= '0;
      ld_data_reg <= '0;
      base_wb_reg <= '0;
      lat_cnt_reg <= '0;
      store_reg   <= 1'b0;
      wb_en_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            dar_reg     <= addr_sel;
            mdr_reg     <= st_data;
            lat_cnt_reg <= '0;
            store_reg   <= op_store;
            wb_en_reg   <= mode_has_wb(mode);
            // Writeback value is fixed at request time, so base may change
            // while the access is in flight.
            if (mode_has_wb(mode)) base_wb_reg <= wb_value;
          end
        end
        ST_ACCESS: begin
          if (!store_reg) begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
            if (lat_cnt_reg == LAST_CNT) ld_data_reg <= mem_d_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign mem_w_en   = (state_reg == ST_ACCESS) && store_reg;
  assign base_wb_en = done & wb_en_reg;
  assign base_wb    = base_wb_reg;
  assign ld_data    = ld_data_reg;
  assign mem_addr   = dar_reg;
  assign mem_d_out  = mdr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit (DATA_W=8, ADDR_W=10, MEM_LAT=3).
// Contains a latency-3 synchronous memory model, a table of hand-computed
// vectors, hand-written reset / ignored-start sequences, and a randomized
// phase checked against a shadow memory reference model.
// With MEM_ACCESS_BOUNDS_CHECK_EN defined it uses IMM_W=9, MEM_LIMIT=0x100
// and adds the out-of-range sequence.
module tb_mem_access_unit;

  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int LAT = 3;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam int IW  = 9;
  localparam int ML  = 256;
`else
  localparam int IW  = 8;
  localparam int ML  = 1024;
`endif

  typedef struct {
    logic          op_store;
    logic [1:0]    mode;
    logic [IW-1:0] imm;
    logic [DW-1:0] base;
    logic [DW-1:0] st_data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_ld;
    logic          exp_wb_en;
    logic [DW-1:0] exp_wb;
    logic          exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op_store = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [IW-1:0] imm = '0;
  logic [DW-1:0] base = '0;
  logic [DW-1:0] st_data = '0;
  logic          busy, done, base_wb_en, err, mem_w_en;
  logic [DW-1:0] ld_data, base_wb, mem_d_out, mem_d_in;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W (DW), .ADDR_W (AW), .IMM_W (IW), .MEM_LAT (LAT), .MEM_LIMIT (ML)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .op_store (op_store),
    .mode (mode), .imm (imm), .base (base), .st_data (st_data),
    .busy (busy), .done (done), .ld_data (ld_data), .base_wb (base_wb),
    .base_wb_en (base_wb_en), .err (err), .mem_addr (mem_addr),
    .mem_w_en (mem_w_en), .mem_d_out (mem_d_out), .mem_d_in (mem_d_in)
  );

  // Memory model: read data for an address appears in the LAT-th cycle
  // that address is presented.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:LAT-2];
  logic          mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i * 7 + 3);
    end else if (mem_w_en) begin
      mem[mem_addr] <= mem_d_out;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_d_in = rd_pipe[LAT-2];

  // Reference state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] ld_hold;

  // Observations from one transaction.
  int            obs_busy, obs_wen, obs_addr_bad;
  bit            obs_done;
  logic [AW-1:0] obs_waddr;
  logic [DW-1:0] obs_wdata, obs_ld, obs_wb;
  logic          obs_wb_en, obs_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic is_oob(input logic [AW-1:0] a);
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    return int'(a) >= ML;
`else
    return (a !== a);
`endif
  endfunction

  // Reference model: expectations derived from the addressing rules and the
  // shadow memory.
  function automatic vec_t model(input logic op, input logic [1:0] m,
                                 input logic [IW-1:0] im, input logic [DW-1:0] b,
                                 input logic [DW-1:0] sd);
    vec_t v;
    v.op_store  = op;
    v.mode      = m;
    v.imm       = im;
    v.base      = b;
    v.st_data   = sd;
    v.exp_addr  = (m == 2'b00) ? AW'(im) : AW'(b);
    v.exp_err   = is_oob(v.exp_addr);
    v.exp_ld    = ref_mem[v.exp_addr];
    v.exp_wb_en = (m >= 2'b10);
    v.exp_wb    = (m == 2'b11) ? DW'((int'(b) + 255) % 256) : DW'((int'(b) + 1) % 256);
    return v;
  endfunction

  // Issue one request in the next IDLE cycle, observe until done (bounded),
  // compare, then update the reference state. If poke is set, a second start
  // is raised during the first ACCESS cycle and must be ignored.
  task automatic run_txn(input int id, input vec_t v, input bit poke);
    int            exp_busy;
    logic [DW-1:0] exp_ld;
    @(negedge clk);
    op_store = v.op_store; mode = v.mode; imm = v.imm; base = v.base;
    st_data = v.st_data; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble request inputs: everything must have been captured at start.
    base = ~v.base; st_data = ~v.st_data; imm = ~v.imm; mode = ~v.mode;
    op_store = ~v.op_store;
    obs_busy = 0; obs_wen = 0; obs_addr_bad = 0; obs_done = 0;
    obs_waddr = '0; obs_wdata = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (busy) obs_busy++;
      if (mem_w_en) begin obs_wen++; obs_waddr = mem_addr; obs_wdata = mem_d_out; end
      if (busy && !done && mem_addr !== v.exp_addr) obs_addr_bad++;
      if (done) begin
        obs_done = 1; obs_ld = ld_data; obs_wb = base_wb;
        obs_wb_en = base_wb_en; obs_err = err;
        break;
      end
      start = (poke && cyc == 0);
      @(negedge clk);
    end
    start = 1'b0;

    exp_busy = v.exp_err ? 1 : (v.op_store ? 2 : LAT + 1);
    exp_ld   = (v.op_store || v.exp_err) ? ld_hold : v.exp_ld;
    chk($sformatf("t%0d done_seen", id), 32'(obs_done), 32'd1);
    chk($sformatf("t%0d busy_cycles", id), 32'(obs_busy), 32'(exp_busy));
    chk($sformatf("t%0d wen_cycles", id), 32'(obs_wen), (v.op_store && !v.exp_err) ? 32'd1 : 32'd0);
    if (v.op_store && !v.exp_err) begin
      chk($sformatf("t%0d wr_addr", id), 32'(obs_waddr), 32'(v.exp_addr));
      chk($sformatf("t%0d wr_data", id), 32'(obs_wdata), 32'(v.st_data));
    end
    if (!v.exp_err) chk($sformatf("t%0d addr_held", id), 32'(obs_addr_bad), 32'd0);
    chk($sformatf("t%0d ld_data", id), 32'(obs_ld), 32'(exp_ld));
    chk($sformatf("t%0d base_wb_en", id), 32'(obs_wb_en), 32'(v.exp_wb_en));
    if (v.exp_wb_en) chk($sformatf("t%0d base_wb", id), 32'(obs_wb), 32'(v.exp_wb));
    chk($sformatf("t%0d err", id), 32'(obs_err), 32'(v.exp_err));
    $display("txn %0d: st=%0d mode=%0d addr=0x%03h ld=0x%02h wb=0x%02h/%0d err=%0d busy=%0d",
             id, v.op_store, v.mode, v.exp_addr, obs_ld, obs_wb, obs_wb_en, obs_err, obs_busy);

    if (v.op_store && !v.exp_err) ref_mem[v.exp_addr] = v.st_data;
    if (!v.op_store && !v.exp_err) ld_hold = v.exp_ld;
  endtask

  vec_t vecs [8];
  vec_t rv;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i * 7 + 3);
    ld_hold = '0;

    // Hand-computed vectors, applied in order (loads read earlier stores).
    //          st    mode   imm     base   st_data addr     ld     wben  wb     err
    vecs[0] = '{1'b1, 2'b00, 'h2A, 8'h00, 8'h5C, 10'h02A, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 2'b01, 'h00, 8'h10, 8'hA7, 10'h010, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 2'b01, 'h00, 8'h10, 8'h00, 10'h010, 8'hA7, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 2'b00, 'h2A, 8'h33, 8'h00, 10'h02A, 8'h5C, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 2'b10, 'h00, 8'hFF, 8'h3C, 10'h0FF, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 2'b10, 'h00, 8'hFF, 8'h00, 10'h0FF, 8'h3C, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 2'b11, 'h00, 8'h00, 8'h99, 10'h000, 8'h00, 1'b1, 8'hFF, 1'b0};
    vecs[7] = '{1'b0, 2'b11, 'h00, 8'h00, 8'h00, 10'h000, 8'h99, 1'b1, 8'hFF, 1'b0};

    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;

    // Reset state.
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst mem_w_en", 32'(mem_w_en), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst base_wb_en", 32'(base_wb_en), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_d_out", 32'(mem_d_out), 32'd0);
    chk("rst ld_data", 32'(ld_data), 32'd0);
    chk("rst base_wb", 32'(base_wb), 32'd0);

    // Table-driven vectors, issued back to back (start in the cycle after done).
    for (int i = 0; i < 8; i++) run_txn(i, vecs[i], 1'b0);

    // Start during ACCESS is ignored and not queued.
    run_txn(100, model(1'b0, 2'b01, '0, 8'h2A, 8'h00), 1'b1);
    @(negedge clk);
    chk("noqueue busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("noqueue busy1", 32'(busy), 32'd0);

    // Reset during a store's ACCESS cycle.
    @(negedge clk);
    op_store = 1'b1; mode = 2'b00; imm = IW'(8'h55); st_data = 8'hE1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rstmid wen_before", 32'(mem_w_en), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // The strobe was high during the cycle ending at the reset edge.
    ref_mem[10'h055] = 8'hE1;
    ld_hold = '0;
    chk("rstmid mem_w_en", 32'(mem_w_en), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid dar", 32'(mem_addr), 32'd0);
    chk("rstmid ld_data", 32'(ld_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstmid no_done%0d", i), 32'(done | mem_w_en), 32'd0);
      @(negedge clk);
    end

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    // In-range indirect load, then out-of-range direct load.
    run_txn(200, '{1'b0, 2'b01, 'h000, 8'h80, 8'h00, 10'h080, 8'h83, 1'b0, 8'h00, 1'b0}, 1'b0);
    run_txn(201, '{1'b0, 2'b00, 'h1FF, 8'h00, 8'h00, 10'h1FF, 8'h00, 1'b0, 8'h00, 1'b1}, 1'b0);
    run_txn(202, '{1'b1, 2'b00, 'h1FF, 8'h00, 8'h6E, 10'h1FF, 8'h00, 1'b0, 8'h00, 1'b1}, 1'b0);
`endif

    // Randomized phase against the reference model. A small address pool
    // makes loads revisit stored locations.
    for (int i = 0; i < 40; i++) begin
      logic [IW-1:0] r_imm;
      r_imm = ($urandom % 4 == 0) ? IW'($urandom_range(0, (1 << IW) - 1))
                                  : IW'($urandom_range(0, 15));
      rv = model(1'($urandom), 2'($urandom), r_imm,
                 DW'($urandom_range(0, 15) | (($urandom % 3 == 0) ? 8'hF0 : 8'h00)),
                 DW'($urandom));
      run_txn(300 + i, rv, 1'($urandom % 5 == 0) && !rv.op_store);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor of the processor's data-memory access path: DAR/MDR, direct and indirect addressing, load/store.
- Generalised in data width, address width and memory read latency.
- Adds a start/busy/done handshake, a multi-cycle access FSM, and post-increment/post-decrement indirect modes with base-register writeback.
- Sits between the control unit/register bank and a synchronous data memory with fixed read latency.

Parameters:
- DATA_W, 8, data word and base-register width.
- ADDR_W, 10, data memory address width; must be >= DATA_W and >= IMM_W.
- IMM_W, 8, immediate address width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4.
- MEM_LIMIT, 1024, first illegal address; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- op_store  in  1  1 = store, 0 = load
- mode  in  2  00 direct, 01 indirect, 10 indirect post-inc, 11 indirect post-dec
- imm  in  IMM_W  direct address
- base  in  DATA_W  register A value (indirect address)
- st_data  in  DATA_W  register B value (store data)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- ld_data  out  DATA_W  last loaded word; held until the next load completes
- base_wb  out  DATA_W  updated base value
- base_wb_en  out  1  pulse with done for modes 10/11
- err  out  1  pulse with done on an aborted access
- mem_addr  out  ADDR_W  memory address (DAR contents)
- mem_w_en  out  1  memory write strobe
- mem_d_out  out  DATA_W  memory write data (MDR contents)
- mem_d_in  in  DATA_W  memory read data

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - DAR, MDR, ld_data, base_wb and the latency counter clear to 0.
  - All strobes (done, base_wb_en, err, mem_w_en) are 0 from the cycle after the reset edge.
  - Reset mid-access aborts the access: no write occurs after the reset edge, and ld_data is not updated.
- States: IDLE, ACCESS, DONE.
- IDLE, start=1 at an edge:
  - DAR <= zero-extended imm (mode 00) or zero-extended base (modes 01-11).
  - MDR <= st_data.
  - Latency counter <= 0.
  - State -> ACCESS.
- start while busy is ignored and is not queued.
- ACCESS, store:
  - mem_w_en=1 for exactly one cycle; mem_addr=DAR, mem_d_out=MDR.
  - Next state DONE.
- ACCESS, load:
  - mem_w_en=0; mem_addr is held for MEM_LAT cycles.
  - The counter increments each cycle.
  - On the edge ending cycle MEM_LAT, ld_data <= mem_d_in and state -> DONE.
- DONE:
  - done=1 for one cycle, then state -> IDLE.
  - A start in the cycle after DONE is accepted (IDLE).
- Latency from the start edge to the done cycle: store 1 cycle of ACCESS, load MEM_LAT cycles.
- Writeback: base_wb = base+1 (mode 10) or base-1 (mode 11), modulo 2^DATA_W; captured at start.
  - 0xFF -> 0x00 and 0x00 -> 0xFF for DATA_W=8.
  - base_wb_en=0 for modes 00/01.
- mem_w_en, busy and done decode from state only; no combinational input-to-output paths except through registers.

Optional Feature:
- Macro MEM_ACCESS_BOUNDS_CHECK_EN.
- Defined:
  - If the computed address >= MEM_LIMIT at start, ACCESS is skipped; state goes IDLE -> DONE directly.
  - No mem_w_en; ld_data is unchanged.
  - err=1 and done=1 together; base_wb_en is still issued.
- Undefined: err is tied 0; MEM_LIMIT is ignored; all addresses are accessed.

Decomposition:
- constants.v holds the mode encodings (`mau_direct`, `mau_indirect`, `mau_post_inc`, `mau_post_dec`) and the state encodings.
- One natural sub-module: mau_addr_gen, combinational address selection, zero-extension, base_wb arithmetic and the bounds compare.
- The top level holds the FSM, DAR/MDR/ld_data registers and the latency counter.

Test Plan:
- Store, mode 00, imm=0x2A, st_data=0x5C -> one mem_w_en cycle with mem_addr=0x02A, mem_d_out=0x5C; done in the following cycle.
- Load, mode 01, base=0x10, MEM_LAT=3, memory[0x10]=0xA7 -> mem_addr held 3 cycles; ld_data=0xA7 when done=1; busy high for 4 cycles.
- Load, mode 10, base=0xFF -> base_wb=0x00 with base_wb_en and done coincident. Mode 11 with base=0x00 -> base_wb=0xFF.
- start pulsed during ACCESS plus back-to-back start right after DONE -> the mid-access start is ignored; the second request is accepted the cycle after done.
- rst_n=0 during a store's ACCESS cycle -> mem_w_en=0 the next cycle; busy=0; DAR=0; no done pulse.
- With MEM_ACCESS_BOUNDS_CHECK_EN and MEM_LIMIT=0x100, load base=0x80 then imm-direct 0x1FF (IMM_W=9) -> the first load is normal; the second gives err=1, done=1, no memory access, ld_data unchanged.
